vai_tx_arbiter: RTL and testbench

- Per-channel Tx request arbiter that shares one upstream CCI-P request channel (c0 or c1) among NUM_REQ requesters: the sub-AFUs plus the manager AFU.
- Each requester gets a private FIFO, so CCI-P almost-full slack is absorbed locally.
- Grants rotate round-robin and a multi-beat request is never interleaved with another source's beats.
- Instantiated once per Tx channel inside the VAI mux, between the per-AFU Tx audit stage and the upstream Tx port.

---
 rtl/vai_pkg.sv | 17 +
 rtl/vai_arb_fifo.sv | 64 ++++++
 rtl/vai_tx_arbiter.sv | 117 +++++++++++
 tb/tb_vai_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vai_pkg.sv
// Shared types and default sizing for the VAI Tx request arbiter.
package vai_pkg;

    localparam int VAI_NUM_REQ       = 9;
    localparam int VAI_DATA_WIDTH    = 600;
    localparam int VAI_FIFO_DEPTH    = 64;
    localparam int VAI_ALMFULL_SLACK = 16;

    typedef logic [$clog2(VAI_NUM_REQ)-1:0] t_vai_req_idx;

    // LOCKED means a multi-beat request is in flight and owns the channel.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } t_arb_state;

endpackage

// File: rtl/vai_arb_fifo.sv
// Single-requester synchronous FIFO. Stores {beat, last}, reports empty,
// a registered almost-full and a sticky overflow flag. A push while full
// is accepted only when a pop frees the head slot in the same cycle.
module vai_arb_fifo
    import vai_pkg::*;
#(
    parameter int WIDTH         = VAI_DATA_WIDTH + 1,
    parameter int FIFO_DEPTH    = VAI_FIFO_DEPTH,
    parameter int ALMFULL_SLACK = VAI_ALMFULL_SLACK
) (
    input  logic             pClk,
    input  logic             SoftReset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             almfull_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] THRESH_C = PW'(FIFO_DEPTH - ALMFULL_SLACK);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, occ;
    logic             full, do_pop, do_push;
    logic             almfull_q, ovf_q;

    assign occ     = wr_ptr_q - rd_ptr_q;
    assign full    = (occ == DEPTH_C);
    assign empty_o = (occ == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign almfull_o = almfull_q;
    assign ovf_o     = ovf_q;

    // Pointers, registered almost-full and sticky overflow.
    always_ff @(posedge pClk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (SoftReset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            almfull_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            almfull_q <= (occ >= THRESH_C);
            if (push_i && !do_push) ovf_q <= 1'b1;
        end
    end

    // Storage write; when full with a same-cycle pop this overwrites the departing head.
    always_ff @(posedge pClk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/vai_tx_arbiter.sv
// Shares one upstream CCI-P Tx channel among NUM_REQ requesters. Each
// requester has a private FIFO; grants rotate round-robin and a multi-beat
// request holds the channel until its last beat has issued.
module vai_tx_arbiter
    import vai_pkg::*;
#(
    parameter int NUM_REQ       = VAI_NUM_REQ,
    parameter int DATA_WIDTH    = VAI_DATA_WIDTH,
    parameter int FIFO_DEPTH    = VAI_FIFO_DEPTH,
    parameter int ALMFULL_SLACK = VAI_ALMFULL_SLACK
) (
    input  logic                               pClk,
    input  logic                               SoftReset,
    input  logic [NUM_REQ-1:0]                 in_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]                 in_last,
    output logic [NUM_REQ-1:0]                 in_almFull,
    input  logic                               up_almFull,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [$clog2(NUM_REQ)-1:0]         out_src,
    output logic [NUM_REQ-1:0]                 ovf_err
);

    localparam int SRC_W = $clog2(NUM_REQ);
    typedef logic [SRC_W-1:0] t_src;

    logic [NUM_REQ-1:0]               fifo_empty, pop;
    logic [NUM_REQ-1:0][DATA_WIDTH:0] head;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        vai_arb_fifo #(
            .WIDTH         (DATA_WIDTH + 1),
            .FIFO_DEPTH    (FIFO_DEPTH),
            .ALMFULL_SLACK (ALMFULL_SLACK)
        ) u_fifo (
            .pClk        (pClk),
            .SoftReset   (SoftReset),
            .push_i      (in_valid[g]),
            .push_data_i ({in_data[g], in_last[g]}),
            .pop_i       (pop[g]),
            .head_o      (head[g]),
            .empty_o     (fifo_empty[g]),
            .almfull_o   (in_almFull[g]),
            .ovf_o       (ovf_err[g])
        );
    end

    t_arb_state            state_q, state_d;
    t_src                  lock_src_q, lock_src_d;
    t_src                  rr_ptr_q, rr_ptr_d;
    t_src                  win;
    logic                  issue;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    t_src                  out_src_q;

    // Pick a winner (lock owner, else first non-empty from rr_ptr) and compute next lock/pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        state_d    = state_q;
        lock_src_d = lock_src_q;
        rr_ptr_d   = rr_ptr_q;
        win        = '0;
        issue      = 1'b0;
        pop        = '0;
        if (state_q == ARB_LOCKED) begin
            win   = lock_src_q;
            issue = !fifo_empty[lock_src_q];
        end else begin
            // Scan from the far end so the candidate closest to rr_ptr is the last one assigned.
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
                if (!fifo_empty[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
                    win   = t_src'((int'(rr_ptr_q) + off) % NUM_REQ);
                    issue = 1'b1;
                end
            end
        end
        if (up_almFull) issue = 1'b0;
        if (issue) begin
            pop[win] = 1'b1;
            if (head[win][0]) begin
                state_d  = ARB_UNLOCKED;
                rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end else begin
                state_d    = ARB_LOCKED;
                lock_src_d = win;
            end
        end
    end

    // Arbiter state and registered upstream output.
    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            state_q     <= ARB_UNLOCKED;
            lock_src_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_src_q  <= lock_src_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= issue;
            if (issue) begin
                out_data_q <= head[win][DATA_WIDTH:1];
                out_src_q  <= win;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_vai_tx_arbiter.sv
// Self-checking bench for vai_tx_arbiter: a scoreboard queue holds the
// expected {source, beat} order, popped whenever out_valid is seen.
module tb_vai_tx_arbiter;
    import vai_pkg::*;

    localparam int NR = 9;
    localparam int DW = 600;

    typedef struct {
        t_vai_req_idx    src;
        logic [DW-1:0]   data;
    } t_exp;

    logic                   pClk = 1'b0;
    logic                   SoftReset;
    logic [NR-1:0]          in_valid;
    logic [NR-1:0][DW-1:0]  in_data;
    logic [NR-1:0]          in_last;
    logic [NR-1:0]          in_almFull;
    logic                   up_almFull;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic [$clog2(NR)-1:0]  out_src;
    logic [NR-1:0]          ovf_err;

    t_exp sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    vai_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(64), .ALMFULL_SLACK(16)
    ) dut (
        .pClk(pClk), .SoftReset(SoftReset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_almFull(in_almFull), .up_almFull(up_almFull),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .ovf_err(ovf_err)
    );

    always #5 pClk = ~pClk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        logic [31:0]   w;
        w = '0;
        for (int i = 0; i < DW; i++) begin
            if (i % 32 == 0) w = $urandom;
            d[i] = w[i % 32];
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic drive(input int r, input logic [DW-1:0] d, input logic last);
        in_valid[r] = 1'b1;
        in_data[r]  = d;
        in_last[r]  = last;
    endtask

    task automatic expect_beat(input int r, input logic [DW-1:0] d);
        t_exp e;
        e.src  = t_vai_req_idx'(r);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge pClk);
            n++;
        end
        check(tag, DW'(sb.size()), '0);
        repeat (3) @(negedge pClk);
    endtask

    // Scoreboard monitor: every issued beat must match the head of the queue.
    always @(negedge pClk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", DW'(out_valid), '0);
            end else begin
                t_exp e;
                e = sb.pop_front();
                check("out_src", DW'(out_src), DW'(e.src));
                check("out_data", out_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d1 [4];
        logic [DW-1:0] d2 [4];
        logic [DW-1:0] db [4];
        logic [DW-1:0] dx;

        SoftReset  = 1'b1;
        up_almFull = 1'b0;
        in_valid   = '0;
        in_last    = '0;
        in_data    = '0;
        repeat (2) tick();
        SoftReset = 1'b0;

        // Reset then idle.
        @(negedge pClk);
        check("rst_out_src", DW'(out_src), '0);
        check("rst_out_data", out_data, '0);
        for (int i = 0; i < 10; i++) begin
            check("idle_out_valid", DW'(out_valid), '0);
            check("idle_in_almFull", DW'(in_almFull), '0);
            check("idle_ovf_err", DW'(ovf_err), '0);
            @(negedge pClk);
        end

        // Three single beats in one cycle: issue order 0, 3, 5.
        foreach (d1[i]) d1[i] = rnd_data();
        expect_beat(0, d1[0]); expect_beat(3, d1[1]); expect_beat(5, d1[2]);
        drive(0, d1[0], 1'b1); drive(3, d1[1], 1'b1); drive(5, d1[2], 1'b1);
        tick();
        idle_inputs();
        @(negedge pClk);
        check("rr_latency_early", DW'(out_valid), '0);
        @(negedge pClk);
        check("rr_latency_first", DW'(out_valid), DW'(1));
        wait_drain("rr_drain", 20);

        // Burst from 2 against singles from 1 (rr_ptr now 6): 1,2,2,2,2,1,1,1.
        foreach (d1[i]) d1[i] = rnd_data();
        foreach (d2[i]) d2[i] = rnd_data();
        expect_beat(1, d1[0]);
        for (int j = 0; j < 4; j++) expect_beat(2, d2[j]);
        for (int j = 1; j < 4; j++) expect_beat(1, d1[j]);
        for (int j = 0; j < 4; j++) begin
            idle_inputs();
            drive(2, d2[j], j == 3);
            drive(1, d1[j], 1'b1);
            tick();
        end
        idle_inputs();
        wait_drain("burst_drain", 30);

        // Fill requester 4 while upstream is stalled.
        up_almFull = 1'b1;
        for (int p = 1; p <= 65; p++) begin
            dx = rnd_data();
            if (p <= 64) expect_beat(4, dx);
            idle_inputs();
            drive(4, dx, 1'b1);
            tick();
            idle_inputs();
            if (p == 47 || p == 48 || p == 49 || p == 64 || p == 65) begin
                @(negedge pClk);
                if (p == 47) check("almfull_47", DW'(in_almFull[4]), '0);
                if (p == 48) check("almfull_48", DW'(in_almFull[4]), '0);
                if (p == 49) check("almfull_after_48", DW'(in_almFull[4]), DW'(1));
                if (p == 64) check("ovf_before", DW'(ovf_err[4]), '0);
                if (p == 65) begin
                    check("ovf_after", DW'(ovf_err[4]), DW'(1));
                    check("stall_no_issue", DW'(out_valid), '0);
                end
            end
        end
        up_almFull = 1'b0;
        wait_drain("fill_drain", 150);
        check("ovf_sticky", DW'(ovf_err), DW'(1 << 4));
        check("almfull_clear", DW'(in_almFull), '0);

        // Locked burst from 8 with a 3-cycle stall; 7 arrives mid-burst and must wait.
        foreach (db[i]) db[i] = rnd_data();
        dx = rnd_data();
        for (int j = 0; j < 4; j++) expect_beat(8, db[j]);
        expect_beat(7, dx);
        drive(8, db[0], 1'b0);
        tick();
        idle_inputs(); drive(8, db[1], 1'b0); drive(7, dx, 1'b1);
        tick();
        idle_inputs(); drive(8, db[2], 1'b0);
        tick();
        idle_inputs(); drive(8, db[3], 1'b1);
        up_almFull = 1'b1;
        tick();
        idle_inputs();
        @(negedge pClk);
        check("lock_stall_1", DW'(out_valid), '0);
        tick();
        @(negedge pClk);
        check("lock_stall_2", DW'(out_valid), '0);
        tick();
        up_almFull = 1'b0;
        @(negedge pClk);
        check("lock_stall_3", DW'(out_valid), '0);
        wait_drain("lock_drain", 30);

        // Reset after beat 2 of a burst from 0; remaining beats must vanish.
        foreach (db[i]) db[i] = rnd_data();
        expect_beat(0, db[0]); expect_beat(0, db[1]);
        for (int j = 0; j < 3; j++) begin
            idle_inputs(); drive(0, db[j], 1'b0);
            tick();
        end
        idle_inputs(); drive(0, db[3], 1'b1);
        SoftReset = 1'b1;
        tick();
        SoftReset = 1'b0;
        idle_inputs();
        @(negedge pClk);
        check("midrst_out_valid", DW'(out_valid), '0);
        check("midrst_ovf_err", DW'(ovf_err), '0);
        check("midrst_in_almFull", DW'(in_almFull), '0);
        check("midrst_sb_consumed", DW'(sb.size()), '0);
        tick();
        @(negedge pClk);
        check("midrst_empty_1", DW'(out_valid), '0);
        tick();
        @(negedge pClk);
        check("midrst_empty_2", DW'(out_valid), '0);
        dx = rnd_data();
        expect_beat(7, dx);
        drive(7, dx, 1'b1);
        tick();
        idle_inputs();
        wait_drain("post_rst_drain", 20);

        check("sb_final_empty", DW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
